csa_result_checker: RTL and testbench
=====================================

# csa_result_checker

Synchronous scoreboard placed directly downstream of the sum and carry QDI-to-binary decoders in the carry-save adder bench. It holds the expected {carry, sum} result for each token sent into the adder in an in-order FIFO. It joins the two decoded result channels, which arrive asynchronously and in either order, then compares them against the oldest expected entry. Pass/fail counts and sticky error flags give self-checking regression over long token streams.

## Interface
Parameters:
- DEPTH, 4, expected-result FIFO depth; power of two, at least 2
- CNT_W, 16, width of pass/fail counters
- SYNC_STAGES, 2, synchronizer flops on each asynchronous valid input; at least 2

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- exp_data  input  3  expected result {co, sum[1:0]}
- exp_push  input  1  push request for exp_data
- exp_ready  output  1  FIFO not full
- sum_rx  input  2  decoded sum; stable whenever sum_valid is high
- sum_valid  input  1  asynchronous level from sum decoder
- co_rx  input  1  decoded carry; stable whenever co_valid is high
- co_valid  input  1  asynchronous level from carry decoder
- pass_cnt  output  CNT_W  matched results
- fail_cnt  output  CNT_W  mismatched or unexpected results
- mismatch  output  1  one-cycle pulse per failed compare
- last_got  output  3  {co, sum} of most recent compare
- last_exp  output  3  expected value used in most recent compare (0 on underflow)
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: result completed with FIFO empty
- seq_err  output  1  sticky: second edge on one channel before the other arrived
- idle  output  1  FSM in IDLE and FIFO empty

## Operation
- Each valid input passes through a SYNC_STAGES-deep flop chain plus one history flop. A rise event is last-stage high while the history flop is low. Falling edges are ignored.
- On a rise event, the matching raw data input (sum_rx or co_rx) is captured into a holding register.
- FSM states: IDLE, HAVE_SUM, HAVE_CO, CHECK.
  - IDLE or CHECK: sum rise alone -> HAVE_SUM; co rise alone -> HAVE_CO; both in the same cycle -> CHECK; neither -> IDLE.
  - HAVE_SUM: co rise -> CHECK. A sum rise sets seq_err, keeps the first captured sum, and stays in HAVE_SUM.
  - HAVE_CO: the mirror image of HAVE_SUM.
  - CHECK lasts exactly one cycle. Rise events during CHECK are taken as in IDLE, so no events are lost.
- CHECK with FIFO non-empty:
  - Pop the head entry and compare it with the holding registers.
  - On equality, increment pass_cnt.
  - Otherwise, increment fail_cnt and pulse mismatch.
  - last_got and last_exp load.
- CHECK with FIFO empty: no pop; set underflow; increment fail_cnt; pulse mismatch; last_exp=0.
- FIFO:
  - A push is accepted when exp_push and exp_ready are both high.
  - exp_push while full sets overflow and drops the data.
  - exp_ready = !full, decoded from the registered occupancy count, so a pop in the same cycle does not raise it.
  - Push and pop in the same cycle on a non-empty FIFO both occur; occupancy is unchanged.
  - Push and pop in the same cycle on an empty FIFO: no bypass, so the CHECK is an underflow and the pushed entry is stored.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Counters saturate at all-ones and do not wrap.
- Reset values:
  - pass_cnt, fail_cnt = 0
  - mismatch, overflow, underflow, seq_err = 0
  - last_got, last_exp = 0
  - exp_ready=1, idle=1
  - FSM in IDLE, FIFO empty, all synchronizer and history flops cleared
- Reset mid-operation discards the partial join and all FIFO contents. A valid level still high when RESET falls produces one rise event after the synchronizer delay.

## Timing
- Let edge k be the first CLK edge that samples a valid input high.
- The last sync stage is high after edge k+SYNC_STAGES-1. The rise event is asserted in that cycle, and the FSM transitions at edge k+SYNC_STAGES.
- If both channels rise in the same cycle, CHECK is occupied during the cycle after edge k+SYNC_STAGES. Counters, mismatch, last_* and the FIFO pop all update at edge k+SYNC_STAGES+1.
- If the channels are separated, latency is measured from the later channel's edge k.
- mismatch is high for exactly one cycle per failed compare.
- A pushed entry is visible to a CHECK one cycle after the accepting edge.
- Minimum valid high/low time: SYNC_STAGES+1 CLK periods. Shorter pulses may be missed and are not flagged.

## Test plan
- Reset: hold RESET 2 cycles, then release -> pass_cnt=0, fail_cnt=0, exp_ready=1, idle=1, all flags 0.
- Push 3'b101; raise sum_valid with sum_rx=01, then 5 cycles later co_valid with co_rx=1 -> pass_cnt=1, mismatch never high, last_got=101, idle=1 afterward.
- Push 3'b011; raise both valids in the same cycle with sum_rx=10 and co_rx=0 -> fail_cnt=1, one-cycle mismatch at edge k+3 (SYNC_STAGES=2), last_exp=011, last_got=010.
- Push 4 entries 0,1,2,3 -> exp_ready=0; fifth push -> overflow=1, occupancy 4. Return results 0,1,2,3 -> pass_cnt=4; results match in order.
- Return a full result with FIFO empty -> underflow=1, fail_cnt increments, last_exp=000. Separately, two sum rises with no carry -> seq_err=1 and state stays HAVE_SUM.
- Assert RESET while in HAVE_SUM with 2 FIFO entries -> idle=1, exp_ready=1, counters 0 at the cycle after RESET falls.

Source files
------------

// File: rtl/csa_result_checker_if.sv
// Result-checker bus: expected-value push port, the two decoded result
// channels from the QDI decoders, and the scoreboard status outputs.
interface csa_result_checker_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       exp_data;
  logic             exp_push;
  logic             exp_ready;
  logic [1:0]       sum_rx;
  logic             sum_valid;
  logic             co_rx;
  logic             co_valid;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             mismatch;
  logic [2:0]       last_got;
  logic [2:0]       last_exp;
  logic             overflow;
  logic             underflow;
  logic             seq_err;
  logic             idle;

  // Bench / stimulus side
  modport master (
    output exp_data, exp_push, sum_rx, sum_valid, co_rx, co_valid,
    input  exp_ready, pass_cnt, fail_cnt, mismatch, last_got, last_exp,
           overflow, underflow, seq_err, idle
  );

  // Checker side
  modport slave (
    input  exp_data, exp_push, sum_rx, sum_valid, co_rx, co_valid,
    output exp_ready, pass_cnt, fail_cnt, mismatch, last_got, last_exp,
           overflow, underflow, seq_err, idle
  );
endinterface

// File: rtl/csa_result_checker.sv
// Scoreboard behind the CSA sum/carry decoders: synchronises the two
// asynchronous valid levels, joins the channels in either order, and
// compares each completed result with the oldest expected FIFO entry.
module csa_result_checker #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  csa_result_checker_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HAVE_SUM = 2'd1,
    HAVE_CO  = 2'd2,
    CHECK    = 2'd3
  } state_e;

  // Saturating counter increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_e              state_q, state_d;

  logic [SYNC_STAGES-1:0] sum_sync_q, co_sync_q;
  logic                sum_hist_q, co_hist_q;
  logic                sum_rise, co_rise;

  logic [1:0]          sum_hold_q;
  logic                co_hold_q;
  logic                sum_cap, co_cap;
  logic                seq_err_set;

  logic [2:0]          mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                fifo_empty, fifo_full;
  logic                push_acc, pop;

  logic                check_active;
  logic [2:0]          got;
  logic [2:0]          head;
  logic                cmp_ok;

  logic [CNT_W-1:0]    pass_cnt_q, fail_cnt_q;
  logic                mismatch_q;
  logic [2:0]          last_got_q, last_exp_q;
  logic                overflow_q, underflow_q, seq_err_q;

  // Rise detection on the synchronised valids; falling edges are ignored.
  assign sum_rise = sum_sync_q[SYNC_STAGES-1] & ~sum_hist_q;
  assign co_rise  = co_sync_q[SYNC_STAGES-1]  & ~co_hist_q;

  // A repeated rise on an already-held channel must not overwrite the first value.
  assign sum_cap = sum_rise && (state_q != HAVE_SUM);
  assign co_cap  = co_rise  && (state_q != HAVE_CO);

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == FULL_CNT);
  assign check_active = (state_q == CHECK);
  assign push_acc     = bus.exp_push && !fifo_full;
  assign pop          = check_active && !fifo_empty;
  assign got          = {co_hold_q, sum_hold_q};
  assign head         = mem_q[rd_ptr_q];
  assign cmp_ok       = pop && (head == got);

  // Synchroniser chains and history flops for both valid levels.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_sync_q <= '0;
      co_sync_q  <= '0;
      sum_hist_q <= 1'b0;
      co_hist_q  <= 1'b0;
    end else begin
      sum_sync_q <= {sum_sync_q[SYNC_STAGES-2:0], bus.sum_valid};
      co_sync_q  <= {co_sync_q[SYNC_STAGES-2:0], bus.co_valid};
      sum_hist_q <= sum_sync_q[SYNC_STAGES-1];
      co_hist_q  <= co_sync_q[SYNC_STAGES-1];
    end
  end

  // Holding registers for the raw decoded data, loaded on an accepted rise.
  always_ff @(posedge CLK) begin
    if (sum_cap) sum_hold_q <= bus.sum_rx;
    if (co_cap)  co_hold_q  <= bus.co_rx;
  end

  // Join FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Join FSM next state; CHECK behaves like IDLE so no rise is lost.
  always_comb begin
    state_d     = state_q;
    seq_err_set = 1'b0;
    unique case (state_q)
      IDLE, CHECK: begin
        if (sum_rise && co_rise) state_d = CHECK;
        else if (sum_rise)       state_d = HAVE_SUM;
        else if (co_rise)        state_d = HAVE_CO;
        else                     state_d = IDLE;
      end
      HAVE_SUM: begin
        if (co_rise)  state_d     = CHECK;
        if (sum_rise) seq_err_set = 1'b1;
      end
      HAVE_CO: begin
        if (sum_rise) state_d     = CHECK;
        if (co_rise)  seq_err_set = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer / occupancy next state; no bypass from push to pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge CLK) begin
    if (push_acc) mem_q[wr_ptr_q] <= bus.exp_data;
  end

  // Compare results, counters and sticky error flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      last_got_q  <= 3'b000;
      last_exp_q  <= 3'b000;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      mismatch_q <= check_active && !cmp_ok;
      if (check_active) begin
        last_got_q <= got;
        last_exp_q <= fifo_empty ? 3'b000 : head;
        if (cmp_ok) pass_cnt_q <= sat_inc(pass_cnt_q);
        else        fail_cnt_q <= sat_inc(fail_cnt_q);
      end
      if (check_active && fifo_empty) underflow_q <= 1'b1;
      if (bus.exp_push && fifo_full)  overflow_q  <= 1'b1;
      if (seq_err_set)                seq_err_q   <= 1'b1;
    end
  end

  assign bus.exp_ready = !fifo_full;
  assign bus.idle      = (state_q == IDLE) && fifo_empty;
  assign bus.pass_cnt  = pass_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.last_got  = last_got_q;
  assign bus.last_exp  = last_exp_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_csa_result_checker.sv
// Bench for csa_result_checker: directed scenarios plus randomized
// push/result traffic against a queue-based scoreboard model.
module tb_csa_result_checker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csa_result_checker_if #(.CNT_W(CNT_W)) bus();

  csa_result_checker #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0]       exp_q[$];
  logic [CNT_W-1:0] m_pass, m_fail;
  bit               m_over, m_under, m_seq;
  logic [2:0]       m_got, m_exp;
  int               m_fail_events = 0;
  int               mm_seen = 0;

  // Count every cycle in which mismatch is high.
  always @(negedge clk) if (bus.mismatch === 1'b1) mm_seen++;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic void model_reset();
    exp_q.delete();
    m_pass = '0; m_fail = '0;
    m_over = 0; m_under = 0; m_seq = 0;
    m_got = '0; m_exp = '0;
  endfunction

  function automatic void model_result(input logic [2:0] g);
    logic [2:0] e;
    m_got = g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_exp = e;
      if (e == g) begin
        if (m_pass != '1) m_pass++;
      end else begin
        if (m_fail != '1) m_fail++;
        m_fail_events++;
      end
    end else begin
      m_exp = 3'b000;
      m_under = 1;
      if (m_fail != '1) m_fail++;
      m_fail_events++;
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_push(input logic [2:0] v);
    bus.exp_data = v;
    bus.exp_push = 1'b1;
    step(1);
    bus.exp_push = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else m_over = 1;
  endtask

  // One full result token: both channels, optionally separated by gap cycles.
  task automatic send_result(input logic [1:0] s, input logic c,
                             input int gap, input bit co_first);
    bus.sum_rx = s;
    bus.co_rx  = c;
    if (gap == 0) begin
      bus.sum_valid = 1'b1;
      bus.co_valid  = 1'b1;
    end else begin
      if (co_first) bus.co_valid = 1'b1; else bus.sum_valid = 1'b1;
      step(gap);
      if (co_first) bus.sum_valid = 1'b1; else bus.co_valid = 1'b1;
    end
    step(SYNC + 3);
    bus.sum_valid = 1'b0;
    bus.co_valid  = 1'b0;
    step(SYNC + 4);
    model_result({c, s});
  endtask

  // Both channels together, with a push landing on the CHECK edge.
  task automatic push_during_check(input logic [2:0] g, input logic [2:0] pv);
    bus.sum_rx = g[1:0];
    bus.co_rx  = g[2];
    bus.sum_valid = 1'b1;
    bus.co_valid  = 1'b1;
    step(SYNC + 1);
    bus.exp_data = pv;
    bus.exp_push = 1'b1;
    step(1);
    bus.exp_push = 1'b0;
    step(2);
    bus.sum_valid = 1'b0;
    bus.co_valid  = 1'b0;
    step(SYNC + 4);
    model_result(g);
    if (exp_q.size() < DEPTH) exp_q.push_back(pv);
    else m_over = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    model_reset();
    checks++; if (bus.pass_cnt !== '0) begin errors++; $display("FAIL reset_pass_cnt got %0d expected 0", bus.pass_cnt); end
    checks++; if (bus.fail_cnt !== '0) begin errors++; $display("FAIL reset_fail_cnt got %0d expected 0", bus.fail_cnt); end
    checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL reset_exp_ready got %b expected 1", bus.exp_ready); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b expected 1", bus.idle); end
    checks++; if ({bus.mismatch, bus.overflow, bus.underflow, bus.seq_err} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b expected 0000", {bus.mismatch, bus.overflow, bus.underflow, bus.seq_err}); end
    checks++; if ({bus.last_got, bus.last_exp} !== 6'b0)
      begin errors++; $display("FAIL reset_last got %b expected 000000", {bus.last_got, bus.last_exp}); end
  endtask

  task automatic test_sum_then_co();
    int mm0;
    do_push(3'b101);
    mm0 = mm_seen;
    send_result(2'b01, 1'b1, 5, 1'b0);
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL sep_pass_cnt got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (mm_seen !== mm0) begin errors++; $display("FAIL sep_mismatch_cycles got %0d expected %0d", mm_seen - mm0, 0); end
    checks++; if (bus.last_got !== 3'b101) begin errors++; $display("FAIL sep_last_got got %b expected 101", bus.last_got); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL sep_idle got %b expected 1", bus.idle); end
  endtask

  task automatic test_same_cycle();
    do_push(3'b011);
    bus.sum_rx = 2'b10;
    bus.co_rx  = 1'b0;
    bus.sum_valid = 1'b1;
    bus.co_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (bus.mismatch !== (i == SYNC + 1)) begin
        errors++; $display("FAIL same_mismatch_edge_k+%0d got %b expected %b", i, bus.mismatch, (i == SYNC + 1));
      end
    end
    bus.sum_valid = 1'b0;
    bus.co_valid  = 1'b0;
    step(SYNC + 4);
    model_result(3'b010);
    checks++; if (bus.fail_cnt !== m_fail) begin errors++; $display("FAIL same_fail_cnt got %0d expected %0d", bus.fail_cnt, m_fail); end
    checks++; if (bus.last_exp !== 3'b011) begin errors++; $display("FAIL same_last_exp got %b expected 011", bus.last_exp); end
    checks++; if (bus.last_got !== 3'b010) begin errors++; $display("FAIL same_last_got got %b expected 010", bus.last_got); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) do_push(3'(i));
    checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL fill_exp_ready got %b expected 0", bus.exp_ready); end
    do_push(3'b100);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b expected 1", bus.overflow); end
    checks++; if (bus.exp_ready !== 1'b0) begin errors++; $display("FAIL fill_exp_ready_after got %b expected 0", bus.exp_ready); end
    for (int i = 0; i < 4; i++) begin
      send_result(2'(i), 1'b0, i % 3, i[0]);
      checks++; if (bus.last_got !== 3'(i)) begin errors++; $display("FAIL fill_order got %b expected %b", bus.last_got, 3'(i)); end
    end
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL fill_pass_cnt got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL fill_drained_idle got %b expected 1", bus.idle); end
  endtask

  task automatic test_back_to_back();
    do_push(3'b001);
    do_push(3'b110);
    push_during_check(3'b001, 3'b111);
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL b2b_pass_cnt got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL b2b_exp_ready got %b expected 1", bus.exp_ready); end
    send_result(2'b10, 1'b1, 2, 1'b1);
    send_result(2'b11, 1'b1, 0, 1'b0);
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL b2b_pass_cnt2 got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b expected 1", bus.idle); end
    push_during_check(3'b010, 3'b100);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL b2b_empty_underflow got %b expected 1", bus.underflow); end
    checks++; if (bus.last_exp !== 3'b000) begin errors++; $display("FAIL b2b_empty_last_exp got %b expected 000", bus.last_exp); end
    checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL b2b_empty_stored got idle %b expected 0", bus.idle); end
    send_result(2'b00, 1'b1, 1, 1'b0);
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL b2b_stored_pass got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (bus.fail_cnt !== m_fail) begin errors++; $display("FAIL b2b_fail_cnt got %0d expected %0d", bus.fail_cnt, m_fail); end
  endtask

  task automatic test_underflow();
    send_result(2'b11, 1'b1, 2, 1'b1);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b expected 1", bus.underflow); end
    checks++; if (bus.fail_cnt !== m_fail) begin errors++; $display("FAIL unf_fail_cnt got %0d expected %0d", bus.fail_cnt, m_fail); end
    checks++; if (bus.last_exp !== 3'b000) begin errors++; $display("FAIL unf_last_exp got %b expected 000", bus.last_exp); end
    checks++; if (bus.last_got !== 3'b111) begin errors++; $display("FAIL unf_last_got got %b expected 111", bus.last_got); end
  endtask

  task automatic test_random();
    logic [2:0] v;
    int mm0;
    mm0 = mm_seen - m_fail_events;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0 || (exp_q.size() == 0 && $urandom_range(0, 3) != 0)) begin
        v = 3'($urandom);
        do_push(v);
      end else begin
        if (exp_q.size() > 0 && $urandom_range(0, 3) != 0) v = exp_q[0];
        else v = 3'($urandom);
        send_result(v[1:0], v[2], $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
      checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL rnd%0d_pass_cnt got %0d expected %0d", it, bus.pass_cnt, m_pass); end
      checks++; if (bus.fail_cnt !== m_fail) begin errors++; $display("FAIL rnd%0d_fail_cnt got %0d expected %0d", it, bus.fail_cnt, m_fail); end
      checks++; if ({bus.overflow, bus.underflow} !== {m_over, m_under})
        begin errors++; $display("FAIL rnd%0d_flags got %b expected %b", it, {bus.overflow, bus.underflow}, {m_over, m_under}); end
      checks++; if ({bus.last_got, bus.last_exp} !== {m_got, m_exp})
        begin errors++; $display("FAIL rnd%0d_last got %b expected %b", it, {bus.last_got, bus.last_exp}, {m_got, m_exp}); end
      checks++; if (bus.exp_ready !== (exp_q.size() < DEPTH))
        begin errors++; $display("FAIL rnd%0d_exp_ready got %b expected %b", it, bus.exp_ready, (exp_q.size() < DEPTH)); end
      checks++; if (bus.idle !== (exp_q.size() == 0))
        begin errors++; $display("FAIL rnd%0d_idle got %b expected %b", it, bus.idle, (exp_q.size() == 0)); end
    end
    checks++; if (mm_seen - m_fail_events !== mm0)
      begin errors++; $display("FAIL rnd_mismatch_cycles got %0d expected %0d", mm_seen - m_fail_events, mm0); end
    while (exp_q.size() > 0) begin
      v = exp_q[0];
      send_result(v[1:0], v[2], 0, 1'b0);
    end
  endtask

  task automatic test_seq_err();
    logic [CNT_W-1:0] p0, f0;
    p0 = bus.pass_cnt;
    f0 = bus.fail_cnt;
    bus.sum_rx = 2'b01;
    bus.sum_valid = 1'b1;
    step(SYNC + 3);
    bus.sum_valid = 1'b0;
    step(SYNC + 4);
    bus.sum_rx = 2'b10;
    bus.sum_valid = 1'b1;
    step(SYNC + 3);
    bus.sum_valid = 1'b0;
    step(SYNC + 4);
    m_seq = 1;
    checks++; if (bus.seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_flag got %b expected 1", bus.seq_err); end
    checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL seq_err_held got idle %b expected 0", bus.idle); end
    checks++; if ({bus.pass_cnt, bus.fail_cnt} !== {p0, f0})
      begin errors++; $display("FAIL seq_err_counts got %0d/%0d expected %0d/%0d", bus.pass_cnt, bus.fail_cnt, p0, f0); end
  endtask

  task automatic test_reset_mid();
    do_push(3'b010);
    do_push(3'b001);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    model_reset();
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL rmid_idle got %b expected 1", bus.idle); end
    checks++; if (bus.exp_ready !== 1'b1) begin errors++; $display("FAIL rmid_exp_ready got %b expected 1", bus.exp_ready); end
    checks++; if ({bus.pass_cnt, bus.fail_cnt} !== {m_pass, m_fail})
      begin errors++; $display("FAIL rmid_counts got %0d/%0d expected 0/0", bus.pass_cnt, bus.fail_cnt); end
    checks++; if (bus.seq_err !== 1'b0) begin errors++; $display("FAIL rmid_seq_err got %b expected 0", bus.seq_err); end
    do_push(3'b110);
    send_result(2'b10, 1'b1, 0, 1'b0);
    checks++; if (bus.pass_cnt !== m_pass) begin errors++; $display("FAIL rmid_after_pass got %0d expected %0d", bus.pass_cnt, m_pass); end
    checks++; if (bus.fail_cnt !== m_fail) begin errors++; $display("FAIL rmid_after_fail got %0d expected %0d", bus.fail_cnt, m_fail); end
  endtask

  initial begin
    rst = 1'b1;
    bus.exp_data  = 3'b000;
    bus.exp_push  = 1'b0;
    bus.sum_rx    = 2'b00;
    bus.sum_valid = 1'b0;
    bus.co_rx     = 1'b0;
    bus.co_valid  = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_sum_then_co();
    test_same_cycle();
    test_fill_overflow();
    test_back_to_back();
    test_underflow();
    test_random();
    test_seq_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
